reg_view_driver: RTL and testbench

REG_VIEW_DRIVER -- requirements
Module: reg_view_driver

---
 rtl/reg_view_driver.sv | 142 ++++++++++++++
 tb/tb_reg_view_driver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_view_driver.sv
// Register-file viewer: debounced next/prev buttons (or an auto stepper) select a
// register id; the captured 32-bit value is scanned out as 8 hex digits.
module reg_view_driver #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DIGIT_CYCLES    = 4,
    parameter int AUTO_CYCLES     = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        auto_mode,
    output logic [4:0]  reg_out_id,
    input  logic [31:0] reg_out_data,
    output logic [6:0]  seg,
    output logic [7:0]  an
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DG_W = $clog2(DIGIT_CYCLES + 1);
    localparam int AU_W = $clog2(AUTO_CYCLES + 1);

    logic [1:0]            raw;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0]            level_q, level_d;
    logic [1:0]            pulse;
    logic [AU_W-1:0]       auto_cnt_q, auto_cnt_d;
    logic                  auto_tick;
    logic [4:0]            id_q, id_d;
    logic [31:0]           data_q;
    logic [DG_W-1:0]       scan_cnt_q, scan_cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    assign raw = {btn_prev, btn_next};

    // The stability counter only runs while the raw input disagrees with the
    // accepted level; any return to the accepted level throws the count away.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        for (int i = 0; i < 2; i++) begin
            if (raw[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt_d[i] = '0;
                level_d[i]  = raw[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
        pulse = level_d & ~level_q;
    end

    always_comb begin
        auto_cnt_d = '0;
        auto_tick  = 1'b0;
        if (auto_mode) begin
            if (auto_cnt_q == AU_W'(AUTO_CYCLES - 1)) begin
                auto_tick = 1'b1;
            end else begin
                auto_cnt_d = auto_cnt_q + AU_W'(1);
            end
        end
    end

    // Pulses act on the edge that accepts the new level, so id moves with no extra lag.
    always_comb begin
        id_d = id_q;
        if (auto_mode) begin
            if (auto_tick) id_d = id_q + 5'd1;
        end else if (pulse[0] && !pulse[1]) begin
            id_d = id_q + 5'd1;
        end else if (pulse[1] && !pulse[0]) begin
            id_d = id_q - 5'd1;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + DG_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == DG_W'(DIGIT_CYCLES - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end
        an_d  = ~(8'b1 << idx_q);
        seg_d = hex_to_seg(data_q[{idx_q, 2'b00} +: 4]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt_q   <= '0;
            level_q    <= '0;
            auto_cnt_q <= '0;
            id_q       <= '0;
            data_q     <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            an_q       <= 8'b1111_1110;
            seg_q      <= 7'b1000000;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            db_cnt_q   <= db_cnt_d;
            level_q    <= level_d;
            auto_cnt_q <= auto_cnt_d;
            id_q       <= id_d;
            data_q     <= reg_out_data;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign reg_out_id = id_q;
    assign an         = an_q;
    assign seg        = seg_q;

endmodule

// File: tb/tb_reg_view_driver.sv
// Self-checking bench for reg_view_driver: directed steps with randomized bounce,
// checked every cycle against a run-length / cycle-count reference model.
module tb_reg_view_driver;

    localparam int DB = 16;
    localparam int DG = 4;
    localparam int AU = 64;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    // Digits 0..7 of 32'h1234ABCD: D,C,B,A,4,3,2,1
    localparam logic [6:0] DISP [8] = '{
        7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001
    };

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        btn_next = 1'b0;
    logic        btn_prev = 1'b0;
    logic        auto_mode = 1'b0;
    logic [4:0]  reg_out_id;
    logic [31:0] reg_out_data;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic [31:0] regfile [32];

    assign reg_out_data = regfile[reg_out_id];

    reg_view_driver #(
        .DEBOUNCE_CYCLES(DB),
        .DIGIT_CYCLES   (DG),
        .AUTO_CYCLES    (AU)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .auto_mode   (auto_mode),
        .reg_out_id  (reg_out_id),
        .reg_out_data(reg_out_data),
        .seg         (seg),
        .an          (an)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_id, m_n, m_t;
    logic [31:0] m_data;
    int          run [2];
    logic [1:0]  prev_raw, acc;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_id     = 0;
        m_n      = 0;
        m_t      = 0;
        m_data   = '0;
        run[0]   = 0;
        run[1]   = 0;
        prev_raw = '0;
        acc      = '0;
        e_an     = 8'b1111_1110;
        e_seg    = 7'b1000000;
    endtask

    // Called at the rising edge with the inputs the DUT is sampling.
    task automatic model_edge();
        logic [1:0] raw;
        logic [1:0] pulse;
        int         dig;
        if (reset) begin
            model_reset();
            return;
        end
        raw   = {btn_prev, btn_next};
        dig   = (m_n / DG) % 8;
        e_an  = ~(8'b1 << dig);
        e_seg = HEX[(m_data >> (4 * dig)) & 32'hF];
        m_data = regfile[m_id];
        m_n++;
        pulse = '0;
        for (int i = 0; i < 2; i++) begin
            if (run[i] == 0 || raw[i] != prev_raw[i]) run[i] = 1;
            else run[i]++;
            prev_raw[i] = raw[i];
            if (raw[i] != acc[i] && run[i] >= DB) begin
                acc[i]   = raw[i];
                pulse[i] = raw[i];
            end
        end
        if (auto_mode) begin
            m_t++;
            if (m_t % AU == 0) m_id = (m_id + 1) % 32;
        end else begin
            m_t  = 0;
            m_id = (m_id + int'(pulse[0]) - int'(pulse[1]) + 32) % 32;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("id", reg_out_id, m_id);
        check("an", an, e_an);
        check("seg", seg, e_seg);
        check("an_onehot", $countones(~an), 1);
    endtask

    task automatic steps(input int k);
        repeat (k) step();
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) btn_next = v;
        else btn_prev = v;
    endtask

    // One bouncy press: random chatter, stable hold, random chatter, stable release.
    task automatic press(input int which, input int hold);
        int nb;
        nb = $urandom_range(2, 10);
        for (int i = 0; i < nb; i++) begin
            drive(which, 1'($urandom_range(0, 1)));
            step();
        end
        drive(which, 1'b1);
        steps(hold);
        nb = $urandom_range(2, 10);
        for (int i = 0; i < nb; i++) begin
            drive(which, 1'($urandom_range(0, 1)));
            step();
        end
        drive(which, 1'b0);
        steps(20);
    endtask

    initial begin
        logic [7:0] an_exp;
        for (int i = 0; i < 32; i++) regfile[i] = $urandom();
        model_reset();
        steps(3);
        check("rst_id", reg_out_id, 0);
        check("rst_an", an, 8'hFE);
        check("rst_seg", seg, 7'b1000000);
        reset = 1'b0;

        // Bouncing next button, then a long hold: one increment only.
        for (int c = 0; c < 40; c++) begin
            btn_next = ((c / 3) % 2 == 0);
            step();
        end
        check("bounce_id", reg_out_id, 0);
        btn_next = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 15) check("db_before", reg_out_id, 0);
            if (k == 16) check("db_step", reg_out_id, 1);
        end
        steps(100);
        check("db_hold", reg_out_id, 1);
        btn_next = 1'b0;
        steps(20);

        // Wrap in both directions.
        press(1, 20);
        check("prev_to_0", reg_out_id, 0);
        press(1, 20);
        check("wrap_prev", reg_out_id, 31);
        press(0, 20);
        check("wrap_next", reg_out_id, 0);

        // Simultaneous presses cancel.
        press(0, $urandom_range(18, 30));
        btn_next = 1'b1;
        btn_prev = 1'b1;
        steps(20);
        check("both_held", reg_out_id, 1);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        steps(20);
        check("both_release", reg_out_id, 1);

        for (int i = 0; i < 6; i++) press(0, $urandom_range(18, 30));
        check("reach_7", reg_out_id, 7);

        // Async reset mid-debounce; hold continues across release.
        btn_next = 1'b1;
        steps(10);
        check("mid_db_id", reg_out_id, 7);
        #2 reset = 1'b1;
        #1;
        check("async_id", reg_out_id, 0);
        check("async_an", an, 8'hFE);
        check("async_seg", seg, 7'b1000000);
        model_reset();
        steps(2);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 1)  check("release_no_pulse", reg_out_id, 0);
            if (k == 15) check("release_before", reg_out_id, 0);
            if (k == 16) check("release_step", reg_out_id, 1);
        end
        btn_next = 1'b0;
        steps(20);

        // Display scan of a constant word.
        for (int i = 0; i < 32; i++) regfile[i] = 32'h1234ABCD;
        step();
        for (int g = 0; g < 32 && (m_n % 32) != 0; g++) step();
        for (int k = 0; k < 32; k++) begin
            step();
            an_exp = ~(8'b1 << (k / 4));
            check("disp_an", an, an_exp);
            check("disp_seg", seg, DISP[k / 4]);
        end

        // Auto mode from id 30; button activity is ignored.
        for (int i = 0; i < 32; i++) regfile[i] = $urandom();
        press(1, 20);
        press(1, 20);
        press(1, 20);
        check("reach_30", reg_out_id, 30);
        auto_mode = 1'b1;
        for (int k = 1; k <= 128; k++) begin
            btn_next = ((k / 20) % 2 == 1);
            step();
            if (k == 63)  check("auto_before", reg_out_id, 30);
            if (k == 64)  check("auto_31", reg_out_id, 31);
            if (k == 127) check("auto_hold", reg_out_id, 31);
            if (k == 128) check("auto_wrap", reg_out_id, 0);
        end
        auto_mode = 1'b0;
        btn_next  = 1'b0;
        steps(20);
        check("manual_after_auto", reg_out_id, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
